// File: rtl/can_ifc_8051_master.sv
// Host-side master generating 8051-style multiplexed ALE/CS/RD/WR cycles
// from a request/acknowledge register-access port.
module can_ifc_8051_master #(
  parameter int unsigned ALE_CYCLES    = 2,
  parameter int unsigned SETUP_CYCLES  = 1,
  parameter int unsigned STROBE_CYCLES = 4,
  parameter int unsigned HOLD_CYCLES   = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req_i,
  input  logic       we_i,
  input  logic [7:0] addr_i,
  input  logic [7:0] wdata_i,
  output logic       ack_o,
  output logic [7:0] rdata_o,
  output logic       busy_o,
  output logic       ale_o,
  output logic       rd_o,
  output logic       wr_o,
  output logic       cs_can_o,
  inout  wire  [7:0] port_0_io
);

  // state  | meaning
  // IDLE   | bus released, waiting for req_i
  // ADDR   | ale_o high, address driven
  // AHOLD  | ale_o low, address still driven
  // SETUP  | cs_can_o high; write data driven or bus released for read
  // STROBE | rd_o or wr_o high
  // HOLD   | strobe low, cs_can_o still high
  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_AHOLD, S_SETUP, S_STROBE, S_HOLD
  } state_t;

  localparam logic [3:0] ALE_LD    = 4'(ALE_CYCLES - 1);
  localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] STROBE_LD = 4'(STROBE_CYCLES - 1);
  localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYCLES - 1);

  state_t     state_q, state_nxt;
  logic [3:0] cnt_q, cnt_nxt;
  logic       we_q, we_nxt;
  logic [7:0] addr_q, addr_nxt;
  logic [7:0] wdata_q, wdata_nxt;
  logic       tc;

  logic       ack_q, busy_q, ale_q, rd_q, wr_q, cs_q, oe_q;
  logic [7:0] dout_q, rdata_q;
  logic       ack_nxt, busy_nxt, ale_nxt, rd_nxt, wr_nxt, cs_nxt, oe_nxt;
  logic [7:0] dout_nxt;

  assign tc = (cnt_q == 4'd0);

  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = (state_q != S_IDLE && !tc) ? cnt_q - 4'd1 : cnt_q;
    we_nxt    = we_q;
    addr_nxt  = addr_q;
    wdata_nxt = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          state_nxt = S_ADDR;
          cnt_nxt   = ALE_LD;
          we_nxt    = we_i;
          addr_nxt  = addr_i;
          wdata_nxt = wdata_i;
        end
      end
      S_ADDR:   if (tc) begin state_nxt = S_AHOLD;  cnt_nxt = 4'd0;      end
      S_AHOLD:  if (tc) begin state_nxt = S_SETUP;  cnt_nxt = SETUP_LD;  end
      S_SETUP:  if (tc) begin state_nxt = S_STROBE; cnt_nxt = STROBE_LD; end
      S_STROBE: if (tc) begin state_nxt = S_HOLD;   cnt_nxt = HOLD_LD;   end
      S_HOLD:   if (tc) begin state_nxt = S_IDLE;   cnt_nxt = 4'd0;      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  // Bus outputs are decoded from the next state so they leave a flop cleanly.
  always_comb begin
    ale_nxt  = (state_nxt == S_ADDR);
    cs_nxt   = (state_nxt == S_SETUP) || (state_nxt == S_STROBE) ||
               (state_nxt == S_HOLD);
    wr_nxt   = (state_nxt == S_STROBE) && we_nxt;
    rd_nxt   = (state_nxt == S_STROBE) && !we_nxt;
    oe_nxt   = (state_nxt == S_ADDR) || (state_nxt == S_AHOLD) ||
               (cs_nxt && we_nxt);
    dout_nxt = ((state_nxt == S_ADDR) || (state_nxt == S_AHOLD)) ? addr_nxt
                                                                 : wdata_nxt;
    ack_nxt  = (state_q == S_HOLD) && (state_nxt == S_IDLE);
    busy_nxt = (state_nxt != S_IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      ale_q   <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      cs_q    <= 1'b0;
      oe_q    <= 1'b0;
      dout_q  <= 8'h00;
      rdata_q <= 8'h00;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      we_q    <= we_nxt;
      addr_q  <= addr_nxt;
      wdata_q <= wdata_nxt;
      ack_q   <= ack_nxt;
      busy_q  <= busy_nxt;
      ale_q   <= ale_nxt;
      rd_q    <= rd_nxt;
      wr_q    <= wr_nxt;
      cs_q    <= cs_nxt;
      oe_q    <= oe_nxt;
      dout_q  <= dout_nxt;
      // Sample on the edge ending the last strobe cycle, while rd_o is still high.
      if (state_q == S_STROBE && tc && !we_q)
        rdata_q <= port_0_io;
    end
  end

  assign ack_o     = ack_q;
  assign busy_o    = busy_q;
  assign ale_o     = ale_q;
  assign rd_o      = rd_q;
  assign wr_o      = wr_q;
  assign cs_can_o  = cs_q;
  assign rdata_o   = rdata_q;
  assign port_0_io = oe_q ? dout_q : 8'bzzzz_zzzz;

endmodule

// File: tb/tb_can_ifc_8051_master.sv
// Directed bench: default instance with an 8051-style register slave, plus
// minimum and maximum timing instances for phase-length checks.
module tb_can_ifc_8051_master;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] req_v = 3'b000;
  logic       we_t = 1'b0;
  logic [7:0] addr_t = 8'h00;
  logic [7:0] wdata_t = 8'h00;

  wire        ack0, ack1, ack2, busy0, busy1, busy2, ale0, ale1, ale2;
  wire        rd0, rd1, rd2, wr0, wr1, wr2, cs0, cs1, cs2;
  wire  [7:0] rdata0, rdata1, rdata2;
  wire  [7:0] port0, port1, port2;

  wire  [2:0] ack_v  = {ack2, ack1, ack0};
  wire  [2:0] busy_v = {busy2, busy1, busy0};
  wire  [2:0] ale_v  = {ale2, ale1, ale0};
  wire  [2:0] rd_v   = {rd2, rd1, rd0};
  wire  [2:0] wr_v   = {wr2, wr1, wr0};
  wire  [2:0] cs_v   = {cs2, cs1, cs0};
  logic [7:0] pv [3];
  assign pv[0] = port0;
  assign pv[1] = port1;
  assign pv[2] = port2;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  can_ifc_8051_master dut (
    .clk_i(clk), .rst_i(rst), .req_i(req_v[0]), .we_i(we_t), .addr_i(addr_t),
    .wdata_i(wdata_t), .ack_o(ack0), .rdata_o(rdata0), .busy_o(busy0),
    .ale_o(ale0), .rd_o(rd0), .wr_o(wr0), .cs_can_o(cs0), .port_0_io(port0));

  can_ifc_8051_master #(.ALE_CYCLES(1), .SETUP_CYCLES(1), .STROBE_CYCLES(1),
                        .HOLD_CYCLES(1)) dut_min (
    .clk_i(clk), .rst_i(rst), .req_i(req_v[1]), .we_i(we_t), .addr_i(addr_t),
    .wdata_i(wdata_t), .ack_o(ack1), .rdata_o(rdata1), .busy_o(busy1),
    .ale_o(ale1), .rd_o(rd1), .wr_o(wr1), .cs_can_o(cs1), .port_0_io(port1));

  can_ifc_8051_master #(.ALE_CYCLES(15), .SETUP_CYCLES(15), .STROBE_CYCLES(15),
                        .HOLD_CYCLES(15)) dut_max (
    .clk_i(clk), .rst_i(rst), .req_i(req_v[2]), .we_i(we_t), .addr_i(addr_t),
    .wdata_i(wdata_t), .ack_o(ack2), .rdata_o(rdata2), .busy_o(busy2),
    .ale_o(ale2), .rd_o(rd2), .wr_o(wr2), .cs_can_o(cs2), .port_0_io(port2));

  // Register slave on the default instance: latches the address during ALE,
  // commits a write when wr falls, drives read data only while rd and cs are high.
  logic [7:0] mem [256];
  logic [7:0] lat = 8'h00;
  logic [7:0] wd = 8'h00;
  logic       wpend = 1'b0;
  int         wcount = 0;
  int         ack_cnt = 0;
  int         inv_bad = 0;

  assign port0 = (rd0 && cs0) ? mem[lat] : 8'bzzzz_zzzz;

  always @(negedge clk) begin
    if (ale0) lat = port0;
    if (wr0) begin
      wpend = 1'b1;
      wd = port0;
    end else if (wpend) begin
      mem[lat] = wd;
      wcount++;
      wpend = 1'b0;
    end
    if (ack0) ack_cnt++;
    if ((rd0 && wr0) || (ale0 && (cs0 || rd0 || wr0))) inv_bad++;
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // Issue one request to instance idx and count phase lengths until ack.
  // Must be called just after a rising edge with the instance idle.
  task automatic run_txn(input int idx, input logic we, input logic [7:0] addr,
                         input logic [7:0] wdata, output int lat_o,
                         output int ale_n, output int cs_n, output int stb_n,
                         output int viol);
    int k;
    we_t = we; addr_t = addr; wdata_t = wdata; req_v[idx] = 1'b1;
    @(posedge clk); #1;
    req_v[idx] = 1'b0;
    lat_o = -1; ale_n = 0; cs_n = 0; stb_n = 0; viol = 0; k = 0;
    while (k < 100 && lat_o < 0) begin
      if (ack_v[idx]) lat_o = k;
      else begin
        if (ale_v[idx]) begin
          ale_n++;
          if (pv[idx] !== addr) viol++;
        end
        if (cs_v[idx]) cs_n++;
        if (rd_v[idx] || wr_v[idx]) stb_n++;
        if (wr_v[idx] && pv[idx] !== wdata) viol++;
        if (rd_v[idx] && we) viol++;
        if (wr_v[idx] && !we) viol++;
        if ((rd_v[idx] && wr_v[idx]) || (ale_v[idx] && (cs_v[idx] || rd_v[idx] || wr_v[idx])))
          viol++;
        @(posedge clk); #1;
        k++;
      end
    end
  endtask

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rd;
  } vec_t;

  initial begin
    vec_t tbl [7];
    int lt, an, cn, sn, vi, w0, a0, k;

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h07] = 8'h3C;
    mem[8'h02] = 8'h66;

    tbl[0] = '{1'b1, 8'h12, 8'hA5, 8'h00};
    tbl[1] = '{1'b0, 8'h07, 8'h00, 8'h3C};
    tbl[2] = '{1'b1, 8'h40, 8'h5A, 8'h00};
    tbl[3] = '{1'b0, 8'h40, 8'h00, 8'h5A};
    tbl[4] = '{1'b0, 8'h12, 8'h00, 8'hA5};
    tbl[5] = '{1'b1, 8'hFF, 8'h00, 8'h00};
    tbl[6] = '{1'b0, 8'hFF, 8'h00, 8'h00};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", int'({ack_v, busy_v, ale_v, rd_v, wr_v, cs_v}), 0);
    chk("reset_rdata", int'({rdata2, rdata1, rdata0}), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Table-driven transactions on the default instance.
    for (int i = 0; i < 7; i++) begin
      w0 = wcount;
      run_txn(0, tbl[i].we, tbl[i].addr, tbl[i].wdata, lt, an, cn, sn, vi);
      chk($sformatf("v%0d_latency", i), lt, 9);
      chk($sformatf("v%0d_ale_len", i), an, 2);
      chk($sformatf("v%0d_cs_len", i), cn, 6);
      chk($sformatf("v%0d_strobe_len", i), sn, 4);
      chk($sformatf("v%0d_bus", i), vi, 0);
      if (tbl[i].we) begin
        chk($sformatf("v%0d_reg", i), int'(mem[tbl[i].addr]), int'(tbl[i].wdata));
        chk($sformatf("v%0d_wcount", i), wcount - w0, 1);
      end else begin
        chk($sformatf("v%0d_rdata", i), int'(rdata0), int'(tbl[i].exp_rd));
        chk($sformatf("v%0d_wcount", i), wcount - w0, 0);
      end
      @(posedge clk); #1;
      chk($sformatf("v%0d_ack_once", i), int'(ack0), 0);
    end

    // req_i held high: write 0x01 then read 0x02 accepted in the ack cycle.
    we_t = 1'b1; addr_t = 8'h01; wdata_t = 8'hC3; req_v[0] = 1'b1;
    @(posedge clk); #1;
    we_t = 1'b0; addr_t = 8'h02; wdata_t = 8'h00;
    k = 0;
    while (k < 30 && !ack0) begin @(posedge clk); #1; k++; end
    chk("b2b_first_ack", k, 9);
    @(posedge clk); #1; k++;
    chk("b2b_second_ale", int'({ale0, busy0, ack0}), 3'b110);
    req_v[0] = 1'b0;
    while (k < 40 && !ack0) begin @(posedge clk); #1; k++; end
    chk("b2b_second_ack", k, 19);
    chk("b2b_wreg", int'(mem[8'h01]), 8'hC3);
    chk("b2b_rdata", int'(rdata0), 8'h66);
    @(posedge clk); #1;

    // Inputs change and req_i pulses during STROBE of a write.
    a0 = ack_cnt; w0 = wcount;
    fork
      run_txn(0, 1'b1, 8'h30, 8'h11, lt, an, cn, sn, vi);
      begin
        repeat (5) @(posedge clk);
        #1;
        req_v[0] = 1'b1; wdata_t = 8'hFF; addr_t = 8'h99;
        @(posedge clk); #1;
        req_v[0] = 1'b0;
      end
    join
    repeat (15) @(posedge clk);
    #1;
    chk("mid_latency", lt, 9);
    chk("mid_bus", vi, 0);
    chk("mid_reg", int'(mem[8'h30]), 8'h11);
    chk("mid_single_write", wcount - w0, 1);
    chk("mid_single_ack", ack_cnt - a0, 1);
    chk("mid_idle", int'(busy0), 0);

    // Reset during the third STROBE cycle of a read.
    a0 = ack_cnt;
    we_t = 1'b0; addr_t = 8'h07; req_v[0] = 1'b1;
    @(posedge clk); #1;
    req_v[0] = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("rst_pre_rd", int'(rd0), 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_outputs", int'({ack0, busy0, ale0, rd0, wr0, cs0}), 0);
    chk("rst_mid_rdata", int'(rdata0), 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("rst_no_ack", ack_cnt - a0, 0);
    run_txn(0, 1'b0, 8'h07, 8'h00, lt, an, cn, sn, vi);
    chk("post_rst_latency", lt, 9);
    chk("post_rst_rdata", int'(rdata0), 8'h3C);
    @(posedge clk); #1;

    // Parameter sweep on the minimum and maximum timing instances.
    run_txn(1, 1'b1, 8'h5C, 8'h3A, lt, an, cn, sn, vi);
    chk("min_latency", lt, 5);
    chk("min_ale_len", an, 1);
    chk("min_cs_len", cn, 3);
    chk("min_strobe_len", sn, 1);
    chk("min_bus", vi, 0);
    @(posedge clk); #1;
    run_txn(2, 1'b1, 8'hC5, 8'h96, lt, an, cn, sn, vi);
    chk("max_latency", lt, 61);
    chk("max_ale_len", an, 15);
    chk("max_cs_len", cn, 45);
    chk("max_strobe_len", sn, 15);
    chk("max_bus", vi, 0);

    chk("invariants", inv_bad, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/can_ifc_8051_master.md
Name: can_ifc_8051_master

Overview:
Host-side bus master that generates 8051-style multiplexed address/data cycles toward the CAN controller's 8051 register interface. It converts a simple request/acknowledge register-access port into ALE, CS, RD and WR strobe sequences on the shared 8-bit bus. For reads it samples the returned data. It is used as the CPU model in system benches and as the bridge when the controller is hosted by a non-8051 core.

Parameters:
ALE_CYCLES, 2, cycles ale_o is high with the address driven (1..15)
SETUP_CYCLES, 1, cycles cs_can_o is high before the strobe rises (1..15)
STROBE_CYCLES, 4, cycles rd_o or wr_o is high (1..15)
HOLD_CYCLES, 1, cycles after the strobe falls with cs_can_o still high (1..15)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
req_i  in  1  access request; sampled only in IDLE
we_i  in  1  1 = write, 0 = read; captured with req_i
addr_i  in  8  register address; captured with req_i
wdata_i  in  8  write data; captured with req_i
ack_o  out  1  one-cycle completion pulse
rdata_o  out  8  read data; valid from ack_o of a read until the next read ack
busy_o  out  1  transaction in progress
ale_o  out  1  address latch enable, active-high
rd_o  out  1  read strobe, active-high
wr_o  out  1  write strobe, active-high
cs_can_o  out  1  chip select, active-high
port_0_io  inout  8  multiplexed address/data bus

Behaviour:
- Reset is asynchronous. During reset: state IDLE, ack_o=0, busy_o=0, ale_o=0, rd_o=0, wr_o=0, cs_can_o=0, rdata_o=8'h00, port_0_io=Z. Captured address, data and direction clear to 0.
- All bus outputs and the port output-enable are registered, so they are glitch-free.
- A single 4-bit down-counter, loaded with (param-1) on each phase entry, times every phase. Only the FSM changes on terminal count.
- FSM states: IDLE -> ADDR -> AHOLD -> SETUP -> STROBE -> HOLD -> IDLE.
- IDLE: busy_o=0 and the bus is released.
  - req_i=1 at a clock edge captures we_i, addr_i and wdata_i, then moves to ADDR.
- ADDR (ALE_CYCLES cycles): ale_o=1 and port drives the captured address.
- AHOLD (1 cycle): ale_o=0 and the address is still driven, giving hold time after ALE falls.
- SETUP (SETUP_CYCLES cycles): cs_can_o=1.
  - Write: port drives the write data.
  - Read: port is Z, so the bus is released before rd_o rises and no contention can occur.
- STROBE (STROBE_CYCLES cycles): cs_can_o=1, with wr_o=1 for a write or rd_o=1 for a read.
  - Write data stays driven throughout.
  - Read: rdata_o <= port_0_io on the clock edge that ends the last STROBE cycle, while rd_o is still high.
- HOLD (HOLD_CYCLES cycles): strobes are 0 and cs_can_o=1.
  - Write data stays driven.
  - Read: port stays Z.
- Completion timing:
  - Exit from HOLD deasserts cs_can_o and releases the port.
  - ack_o=1 for exactly one cycle, coincident with IDLE.
- busy_o is high from the cycle after acceptance through the last HOLD cycle.
- Latency: ack_o rises N = ALE_CYCLES+1+SETUP_CYCLES+STROBE_CYCLES+HOLD_CYCLES edges after the acceptance edge. With default parameters N=9.
- Back-to-back requests: req_i high during the ack_o cycle is accepted that same cycle, giving a minimum spacing of N+1 cycles between acceptances.
- req_i, we_i, addr_i and wdata_i are ignored while busy. Captured values stay stable even if the inputs change mid-transaction.
- rd_o and wr_o are never high together. ale_o is never high together with cs_can_o, rd_o or wr_o.
- Reset asserted mid-transaction (any state):
  - Immediately forces the reset values, with no ack_o.
  - rdata_o returns to 8'h00.
  - The first request after reset starts a fresh cycle.

Test Plan:
- Default-parameter write, addr 0x12 data 0xA5, with the CAN 8051 interface attached -> ale_o high for 2 cycles with port=0x12; wr_o high for 4 cycles with port=0xA5; exactly one register write of 0xA5 to address 0x12; ack_o exactly 9 edges after acceptance.
- Read of addr 0x07 with the slave returning 0x3C -> port Z from SETUP onward; rd_o high for 4 cycles; rdata_o=0x3C at ack_o; no cycle with both master and slave driving (X check on port_0_io).
- req_i held high continuously: write 0x01 then read 0x02 -> second acceptance in the ack_o cycle of the first; second ale_o rises the next cycle; spacing 10 cycles.
- Mid-transaction input change: wdata_i changes to 0xFF and req_i pulses during STROBE -> bus still shows the originally captured data; no extra transaction; single ack_o.
- rst_i asserted during the 3rd STROBE cycle of a read -> all strobes 0 and port Z immediately; no ack_o; rdata_o=0x00; the next request completes normally.
- Parameter sweep: ALE=1, SETUP=1, STROBE=1, HOLD=1 and ALE=15, SETUP=15, STROBE=15, HOLD=15 -> phase lengths match the parameters; N=5 and N=61 respectively.
